adder_rr_arbiter: RTL and testbench
===================================

// Module: adder_rr_arbiter
// PURPOSE
//  Shares one WIDTH-bit adder datapath (a + b + cin) between two requesters.
//  Round-robin arbitration with valid/ready handshakes on both request ports and on one response port.
//  Result is registered and tagged with the requester ID.
//  Sits between the combinational adder library blocks and any two clients that need occasional adds.
// PARAMETERS
//  WIDTH  4  operand and sum width in bits (>=1)
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst         in   1      asynchronous, active-high reset
//  req0_valid  in   1      requester 0 has an operation pending
//  req0_ready  out  1      requester 0 operation accepted this cycle (when valid)
//  req0_a      in   WIDTH  requester 0 operand a
//  req0_b      in   WIDTH  requester 0 operand b
//  req0_cin    in   1      requester 0 carry-in
//  req1_valid  in   1      requester 1 has an operation pending
//  req1_ready  out  1      requester 1 operation accepted this cycle (when valid)
//  req1_a      in   WIDTH  requester 1 operand a
//  req1_b      in   WIDTH  requester 1 operand b
//  req1_cin    in   1      requester 1 carry-in
//  rsp_valid   out  1      response register holds a result
//  rsp_ready   in   1      consumer takes the response this cycle
//  rsp_id      out  1      requester that issued the held result (0/1)
//  rsp_sum     out  WIDTH  (a + b + cin) modulo 2^WIDTH
//  rsp_cout    out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  Reset (async, immediate):
//   - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, prio pointer=0 (requester 0 favoured).
//   - Any in-flight result is discarded; no response is produced for it.
//  Arithmetic:
//   - {rsp_cout, rsp_sum} = a + b + cin, computed at WIDTH+1 bits, unsigned.
//   - Wrap-around modulo 2^WIDTH; the carry is reported only in rsp_cout.
//  FSM, two states:
//   - EMPTY (rsp_valid=0).
//   - FULL (rsp_valid=1).
//  Slot free: free = !rsp_valid || rsp_ready.
//  Grant (combinational):
//   - Only one valid: that requester.
//   - Both valid: requester equal to prio.
//   - reqN_ready = free && grant==N. The ungranted ready is 0. Readies never assert while !free.
//  Accept (reqN_valid && reqN_ready):
//   - Next edge loads sum/cout/id from requester N and sets rsp_valid=1 (FULL).
//   - prio <= ~N, so the other requester wins the next conflict.
//   - prio is unchanged on cycles with no accept.
//  Response:
//   - rsp_valid && rsp_ready with no accept that cycle -> rsp_valid<=0 (EMPTY).
//   - Response pop and new accept in the same cycle -> stays FULL and loads the new result (no bubble).
//  Latency and throughput:
//   - 1 cycle from accept to rsp_valid.
//   - Throughput 1 op/cycle while rsp_ready is held high.
//  Stall: while FULL && !rsp_ready, rsp_* stay stable and both readies stay 0.
//  Requesters hold valid/operands until ready. Dropping valid without a handshake is legal and grants nothing.
//  Starvation-free: with both valid continuously, grants alternate 0,1,0,1...
// TESTING
//  1. Reset: assert rst mid-FULL -> rsp_valid=0 immediately; after release, both valid -> req0 granted first.
//  2. Single op (WIDTH=4): req0 a=1010 b=0101 cin=1, rsp_ready=1 -> next cycle rsp_sum=0000, rsp_cout=1, rsp_id=0.
//  3. Conflict: both valid for 4 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1; one ready high per cycle.
//  4. Backpressure: rsp_ready=0 with result held -> rsp_* stable, req0/1_ready=0 for 5 cycles.
//     Then rsp_ready=1 -> pop and new accept in the same cycle.
//  5. Wrap: req1 a=1111 b=1111 cin=1 -> rsp_sum=1111, rsp_cout=1, rsp_id=1.
//     a=0 b=0 cin=0 -> sum=0000, cout=0.
//  6. Random: 1000 cycles random valid/rsp_ready/operands.
//     Scoreboard per-ID order and sums; check the handshake hold rules and max 1 cycle unfairness under conflict.

Source files
------------

// File: rtl/adder_rr_arbiter.sv
// Two-requester round-robin front end for a single shared WIDTH-bit adder.
// One registered response slot, tagged with the issuing requester, refilled without a bubble.
module adder_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             free;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH:0]   add_full;

  // A lone requester always wins; prio only breaks ties.
  always_comb begin
    grant = prio_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign free       = (state_q == EMPTY) || rsp_ready;
  assign req0_ready = free && !grant;
  assign req1_ready = free && grant;
  assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

  // Operands are muxed ahead of the one shared adder.
  assign op_a     = grant ? req1_a   : req0_a;
  assign op_b     = grant ? req1_b   : req0_b;
  assign op_cin   = grant ? req1_cin : req0_cin;
  assign add_full = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
        end
      end
      FULL: begin
        // A pop with a simultaneous accept keeps the slot full.
        if (!accept && rsp_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      prio_d = ~grant;
      id_d   = grant;
      sum_d  = add_full[WIDTH-1:0];
      cout_d = add_full[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed and randomized checks of the shared-adder round-robin arbiter (WIDTH=4).
module tb_adder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_cin;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_cin;
  logic [3:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [3:0] rsp_sum;

  int checks = 0;
  int errors = 0;

  adder_rr_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  // Leaves the bench 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rst_id got %b want 0", rsp_id); end
    checks++; if (rsp_sum !== 4'h0) begin errors++; $display("FAIL rst_sum got %h want 0", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL rst_cout got %b want 0", rsp_cout); end
    rst = 1'b0;
    tick();
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_cin = 1'b0; rsp_ready = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_pre_ready got %b want 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 4'd7) begin errors++; $display("FAIL rst_fill got v=%b s=%h want v=1 s=7", rsp_valid, rsp_sum); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_sum !== 4'h0) begin errors++; $display("FAIL rst_async got v=%b s=%h want v=0 s=0", rsp_valid, rsp_sum); end
    #2 rst = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5; req1_cin = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_prio got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (rsp_id !== 1'b0 || rsp_sum !== 4'd3) begin errors++; $display("FAIL rst_first got id=%b s=%h want id=0 s=3", rsp_id, rsp_sum); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 4'b1010; req0_b = 4'b0101; req0_cin = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_sum !== 4'b0000) begin errors++; $display("FAIL single_sum got %b want 0000", rsp_sum); end
    checks++; if (rsp_cout !== 1'b1) begin errors++; $display("FAIL single_cout got %b want 1", rsp_cout); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got %b want 0", rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pop got %b want 0", rsp_valid); end
  endtask

  task automatic test_wrap();
    req1_valid = 1'b1; req1_a = 4'b1111; req1_b = 4'b1111; req1_cin = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready got %b want 1", req1_ready); end
    tick();
    req1_a = 4'd0; req1_b = 4'd0; req1_cin = 1'b0;
    checks++; if (rsp_sum !== 4'b1111 || rsp_cout !== 1'b1 || rsp_id !== 1'b1) begin errors++; $display("FAIL wrap_max got s=%b c=%b id=%b want s=1111 c=1 id=1", rsp_sum, rsp_cout, rsp_id); end
    tick();
    req1_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 4'b0000 || rsp_cout !== 1'b0) begin errors++; $display("FAIL wrap_zero got v=%b s=%b c=%b want v=1 s=0000 c=0", rsp_valid, rsp_sum, rsp_cout); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_pop got %b want 0", rsp_valid); end
  endtask

  task automatic test_conflict();
    logic g;
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd8; req1_cin = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      #1;
      checks++; if (req0_ready !== !g || req1_ready !== g) begin errors++; $display("FAIL conflict_ready[%0d] got r0=%b r1=%b want r0=%b r1=%b", k, req0_ready, req1_ready, !g, g); end
      tick();
      checks++;
      if (rsp_id !== g || rsp_sum !== (g ? 4'd2 : 4'd7) || rsp_cout !== g) begin
        errors++; $display("FAIL conflict_rsp[%0d] got id=%b s=%h c=%b want id=%b s=%h c=%b", k, rsp_id, rsp_sum, rsp_cout, g, g ? 4'd2 : 4'd7, g);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL conflict_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_cin = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready got %b want 1", req0_ready); end
    tick();
    req0_a = 4'd6; req0_b = 4'd7; req0_cin = 1'b1;
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_cin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got r0=%b r1=%b want 0 0", k, req0_ready, req1_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 4'd5 || rsp_id !== 1'b0 || rsp_cout !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got v=%b s=%h id=%b c=%b want v=1 s=5 id=0 c=0", k, rsp_valid, rsp_sum, rsp_id, rsp_cout); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready); end
    tick();
    req1_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_sum !== 4'd2) begin errors++; $display("FAIL bp_nobubble got v=%b id=%b s=%h want v=1 id=1 s=2", rsp_valid, rsp_id, rsp_sum); end
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_next_ready got %b want 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_sum !== 4'd14 || rsp_cout !== 1'b0) begin errors++; $display("FAIL bp_second got v=%b id=%b s=%h c=%b want v=1 id=0 s=e c=0", rsp_valid, rsp_id, rsp_sum, rsp_cout); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_random();
    int q0[$];
    int q1[$];
    logic exp_prio, exp_full, exp_free, exp_g, acc0, acc1, done0, done1, stall_prev;
    logic [5:0] prev_rsp;
    int want;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    exp_prio = 1'b0; exp_full = 1'b0; done0 = 1'b0; done1 = 1'b0; stall_prev = 1'b0; prev_rsp = '0;
    for (int cyc = 0; cyc < 1004; cyc++) begin
      if (cyc < 1000) begin
        if (!req0_valid || done0) begin
          req0_valid = ($urandom_range(0, 9) < 6);
          req0_a = 4'($urandom); req0_b = 4'($urandom); req0_cin = 1'($urandom);
        end else if ($urandom_range(0, 19) == 0) begin
          req0_valid = 1'b0;
        end
        if (!req1_valid || done1) begin
          req1_valid = ($urandom_range(0, 9) < 6);
          req1_a = 4'($urandom); req1_b = 4'($urandom); req1_cin = 1'($urandom);
        end else if ($urandom_range(0, 19) == 0) begin
          req1_valid = 1'b0;
        end
        rsp_ready = ($urandom_range(0, 9) < 7);
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      end
      #1;
      checks++; if (rsp_valid !== exp_full) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", cyc, rsp_valid, exp_full); end
      if (stall_prev) begin
        checks++; if ({rsp_id, rsp_cout, rsp_sum} !== prev_rsp) begin errors++; $display("FAIL rnd_stall[%0d] got %h want %h", cyc, {rsp_id, rsp_cout, rsp_sum}, prev_rsp); end
      end
      exp_free = !exp_full || rsp_ready;
      exp_g = (req0_valid && !req1_valid) ? 1'b0 : (req1_valid && !req0_valid) ? 1'b1 : exp_prio;
      if (req0_valid) begin
        checks++; if (req0_ready !== (exp_free && !exp_g)) begin errors++; $display("FAIL rnd_ready0[%0d] got %b want %b", cyc, req0_ready, exp_free && !exp_g); end
      end
      if (req1_valid) begin
        checks++; if (req1_ready !== (exp_free && exp_g)) begin errors++; $display("FAIL rnd_ready1[%0d] got %b want %b", cyc, req1_ready, exp_free && exp_g); end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if ((rsp_id ? q1.size() : q0.size()) == 0) begin
          errors++; $display("FAIL rnd_spurious[%0d] got id=%b s=%h want no response", cyc, rsp_id, rsp_sum);
        end else begin
          want = rsp_id ? q1.pop_front() : q0.pop_front();
          if ({rsp_cout, rsp_sum} !== 5'(want)) begin errors++; $display("FAIL rnd_sum[%0d] id=%b got %h want %h", cyc, rsp_id, {rsp_cout, rsp_sum}, 5'(want)); end
        end
      end
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0) begin q0.push_back(int'(req0_a) + int'(req0_b) + int'(req0_cin)); exp_prio = 1'b1; end
      if (acc1) begin q1.push_back(int'(req1_a) + int'(req1_b) + int'(req1_cin)); exp_prio = 1'b0; end
      exp_full = (acc0 || acc1) ? 1'b1 : (exp_full && rsp_ready) ? 1'b0 : exp_full;
      done0 = acc0; done1 = acc1;
      stall_prev = rsp_valid && !rsp_ready;
      prev_rsp = {rsp_id, rsp_cout, rsp_sum};
      tick();
    end
    checks++; if (q0.size() + q1.size() != 0) begin errors++; $display("FAIL rnd_leftover got %0d want 0", q0.size() + q1.size()); end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_conflict();
    test_backpressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
